alu_issue_seq: RTL and testbench

- Initiator side of the 32-bit ALU interface (opcode/shiftamt/operandA/operandB in; result/overflow out).
- Accepts instruction words over a valid/ready handshake and decodes R-type ALU ops and addi.
- Reads source registers through an external register-file read port, drives the ALU, captures the result one cycle later, and issues a register writeback.
- Overflow redirects the writeback to the status register with a cause code.

---
 rtl/alu_issue_seq.sv | 99 +++++++++
 tb/tb_alu_issue_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues decoded R-type/addi instructions to a 32-bit ALU and writes the result back
//   Ports: clock/reset (async, active-low); insn_valid/insn/insn_ready instruction handshake;
//   rs_addr/rt_addr/rs_data/rt_data register-file read port; alu_* ALU drive and response;
//   wb_valid/wb_addr/wb_data writeback strobe; illegal decode pulse; ovf_trap sticky overflow flag.
//   Optional: define ALU_ISSUE_OVF_TRAP_EN to make overflow set ovf_trap and halt intake.
module alu_issue_seq #(
  parameter logic [4:0]  RSTATUS_REG   = 5'd30,
  parameter logic [31:0] ADD_OVF_CODE  = 32'd1,
  parameter logic [31:0] ADDI_OVF_CODE = 32'd2,
  parameter logic [31:0] SUB_OVF_CODE  = 32'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        insn_valid,
  input  logic [31:0] insn,
  output logic        insn_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        ovf_trap
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
  localparam logic [1:0] K_OTHER = 2'd0, K_ADD = 2'd1, K_SUB = 2'd2, K_ADDI = 2'd3;
  logic [1:0]  state, kind_q, kind_d;
  logic [4:0]  op, rd, shamt, aluop, rd_q;
  logic        is_r, is_addi, legal, accept, ovf;
  logic [31:0] code;
  assign op      = insn[31:27];
  assign rd      = insn[26:22];
  assign rs_addr = insn[21:17];
  assign rt_addr = insn[16:12];
  assign shamt   = insn[11:7];
  assign aluop   = insn[6:2];
  assign is_r    = (op == 5'd0) && (aluop <= 5'd5);
  assign is_addi = op == 5'd5;
  assign legal   = is_r | is_addi;
  assign insn_ready = (state == IDLE) & ~ovf_trap;
  assign accept  = insn_valid & insn_ready;
  always_comb begin
    kind_d = is_addi ? K_ADDI : aluop == 5'd0 ? K_ADD : aluop == 5'd1 ? K_SUB : K_OTHER;
    ovf    = alu_overflow & (kind_q != K_OTHER);
    code   = kind_q == K_ADD ? ADD_OVF_CODE : kind_q == K_SUB ? SUB_OVF_CODE : ADDI_OVF_CODE;
  end
`ifndef ALU_ISSUE_OVF_TRAP_EN
  assign ovf_trap = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      kind_q       <= K_OTHER;
      rd_q         <= 5'd0;
      alu_operandA <= 32'd0;
      alu_operandB <= 32'd0;
      alu_opcode   <= 5'd0;
      alu_shiftamt <= 5'd0;
      wb_valid     <= 1'b0;
      wb_addr      <= 5'd0;
      wb_data      <= 32'd0;
      illegal      <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
      ovf_trap     <= 1'b0;
`endif
    end else begin
      illegal  <= accept & ~legal;
      wb_valid <= 1'b0;
      if (accept && legal) begin
        state        <= EXEC;
        alu_operandA <= rs_data;
        alu_operandB <= is_addi ? {{15{insn[16]}}, insn[16:0]} : rt_data;
        alu_opcode   <= is_addi ? 5'd0 : aluop;
        alu_shiftamt <= is_addi ? 5'd0 : shamt;
        rd_q         <= rd;
        kind_q       <= kind_d;
      end else if (state == EXEC) begin
        state    <= WB;
        // r0 is never written, but an overflow redirect to the status register still is
        wb_valid <= ovf | (rd_q != 5'd0);
        wb_addr  <= ovf ? RSTATUS_REG : rd_q;
        wb_data  <= ovf ? code : alu_result;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        if (ovf) ovf_trap <= 1'b1;
`endif
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed self-checking bench for alu_issue_seq with a behavioural ALU
module tb_alu_issue_seq;
  logic        clock = 1'b0, reset = 1'b0, insn_valid = 1'b0, force_ovf = 1'b0;
  logic [31:0] insn = 32'd0, rs_data = 32'd0, rt_data = 32'd0;
  logic        insn_ready, alu_overflow, wb_valid, illegal, ovf_trap;
  logic [4:0]  rs_addr, rt_addr, alu_opcode, alu_shiftamt, wb_addr;
  logic [31:0] alu_operandA, alu_operandB, alu_result, wb_data;
  int checks = 0, errors = 0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  alu_issue_seq dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .insn(insn), .insn_ready(insn_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_opcode(alu_opcode),
    .alu_shiftamt(alu_shiftamt), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal), .ovf_trap(ovf_trap)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = force_ovf;
    case (alu_opcode)
      5'd0: begin
        alu_result   = alu_operandA + alu_operandB;
        alu_overflow = force_ovf | ((alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]));
      end
      5'd1: begin
        alu_result   = alu_operandA - alu_operandB;
        alu_overflow = force_ovf | ((alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]));
      end
      5'd2: alu_result = alu_operandA & alu_operandB;
      5'd3: alu_result = alu_operandA | alu_operandB;
      5'd4: alu_result = alu_operandA << alu_shiftamt;
      5'd5: alu_result = $unsigned($signed(alu_operandA) >>> alu_shiftamt);
      default: alu_result = 32'd0;
    endcase
  end

  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_insn(input logic [4:0] rd, rs, rt, sh, fn);
    return {5'd0, rd, rs, rt, sh, fn, 2'b00};
  endfunction

  function automatic logic [31:0] i_insn(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // offers w and returns at the falling edge of the cycle after acceptance
  task send(input string tag, input logic [31:0] w);
    @(negedge clock);
    insn = w;
    insn_valid = 1'b1;
    check({tag, ".ready_in"}, {31'd0, insn_ready}, 32'd1);
    @(negedge clock);
    insn_valid = 1'b0;
  endtask

  task run_op(input string tag, input logic [31:0] w, rsd, rtd, ea, eb, input logic [4:0] eop, esh,
              input bit ev, input logic [4:0] eaddr, input logic [31:0] edata, input bit eovf);
    rs_data = rsd;
    rt_data = rtd;
    send(tag, w);
    check({tag, ".opA"}, alu_operandA, ea);
    check({tag, ".opB"}, alu_operandB, eb);
    check({tag, ".opcode"}, {27'd0, alu_opcode}, {27'd0, eop});
    check({tag, ".shamt"}, {27'd0, alu_shiftamt}, {27'd0, esh});
    check({tag, ".ready_exec"}, {31'd0, insn_ready}, 32'd0);
    check({tag, ".wbv_exec"}, {31'd0, wb_valid}, 32'd0);
    @(negedge clock);
    check({tag, ".wbv"}, {31'd0, wb_valid}, {31'd0, ev});
    if (ev) begin
      check({tag, ".wb_addr"}, {27'd0, wb_addr}, {27'd0, eaddr});
      check({tag, ".wb_data"}, wb_data, edata);
    end
    check({tag, ".ready_wb"}, {31'd0, insn_ready}, 32'd0);
    check({tag, ".trap"}, {31'd0, ovf_trap}, {31'd0, eovf & TRAP});
    @(negedge clock);
    check({tag, ".wbv_after"}, {31'd0, wb_valid}, 32'd0);
    check({tag, ".ready_after"}, {31'd0, insn_ready}, {31'd0, !(eovf & TRAP)});
  endtask

  task run_ill(input string tag, input logic [31:0] w);
    send(tag, w);
    check({tag, ".illegal"}, {31'd0, illegal}, 32'd1);
    check({tag, ".ready"}, {31'd0, insn_ready}, 32'd1);
    check({tag, ".wbv"}, {31'd0, wb_valid}, 32'd0);
    @(negedge clock);
    check({tag, ".illegal_off"}, {31'd0, illegal}, 32'd0);
    check({tag, ".wbv_off"}, {31'd0, wb_valid}, 32'd0);
  endtask

  task rst_pulse;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    check("rst.opA", alu_operandA, 32'd0);
    check("rst.wbv", {31'd0, wb_valid}, 32'd0);
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    check("rst.trap", {31'd0, ovf_trap}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst.ready", {31'd0, insn_ready}, 32'd1);

    run_op("add", r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd0), 32'd5, 32'd7, 32'd5, 32'd7, 5'd0, 5'd0, 1, 5'd3, 32'd12, 0);
    check("add.rs_addr", {27'd0, rs_addr}, 32'd1);
    check("add.rt_addr", {27'd0, rt_addr}, 32'd2);
    run_op("addi", i_insn(5'd5, 5'd4, 5'd1, 17'h1FFFF), 32'd10, 32'd0, 32'd10, 32'hFFFFFFFF, 5'd0, 5'd0, 1, 5'd4, 32'd9, 0);
    run_op("sll", r_insn(5'd6, 5'd1, 5'd0, 5'd4, 5'd4), 32'd1, 32'd0, 32'd1, 32'd0, 5'd4, 5'd4, 1, 5'd6, 32'h10, 0);
    run_op("sll_r0", r_insn(5'd0, 5'd1, 5'd0, 5'd4, 5'd4), 32'd1, 32'd0, 32'd1, 32'd0, 5'd4, 5'd4, 0, 5'd0, 32'd0, 0);
    run_op("sra", r_insn(5'd8, 5'd2, 5'd0, 5'd4, 5'd5), 32'h80000000, 32'd0, 32'h80000000, 32'd0, 5'd5, 5'd4, 1, 5'd8, 32'hF8000000, 0);
    force_ovf = 1'b1;
    run_op("or_ovf", r_insn(5'd9, 5'd1, 5'd2, 5'd0, 5'd3), 32'hF0, 32'h0F, 32'hF0, 32'h0F, 5'd3, 5'd0, 1, 5'd9, 32'hFF, 0);
    force_ovf = 1'b0;
    run_ill("ill_op", i_insn(5'd7, 5'd3, 5'd1, 17'd0));
    run_ill("ill_fn", r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd6));

    run_op("sub_ovf", r_insn(5'd5, 5'd1, 5'd2, 5'd0, 5'd1), 32'h80000000, 32'd1, 32'h80000000, 32'd1, 5'd1, 5'd0, 1, 5'd30, 32'd3, 1);
    rst_pulse();
    run_op("add_ovf", r_insn(5'd5, 5'd1, 5'd2, 5'd0, 5'd0), 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd0, 1, 5'd30, 32'd1, 1);
    rst_pulse();
    run_op("addi_ovf", i_insn(5'd5, 5'd5, 5'd1, 17'd1), 32'h7FFFFFFF, 32'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 5'd0, 1, 5'd30, 32'd2, 1);
    rst_pulse();

    rs_data = 32'd1;
    rt_data = 32'd2;
    send("mid", r_insn(5'd7, 5'd1, 5'd2, 5'd0, 5'd0));
    reset = 1'b0;
    #1;
    check("mid.opA", alu_operandA, 32'd0);
    check("mid.opB", alu_operandB, 32'd0);
    check("mid.opcode", {27'd0, alu_opcode}, 32'd0);
    check("mid.wb_addr", {27'd0, wb_addr}, 32'd0);
    check("mid.wb_data", wb_data, 32'd0);
    check("mid.ready", {31'd0, insn_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mid.no_wb", {31'd0, wb_valid}, 32'd0);
    end
    run_op("post", r_insn(5'd3, 5'd1, 5'd2, 5'd0, 5'd0), 32'd20, 32'd22, 32'd20, 32'd22, 5'd0, 5'd0, 1, 5'd3, 32'd42, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
